// File: rtl/button_pkg.sv
// Shared definitions for the button conditioning front end.
//   btn_state_e : arbitration FSM states (idle, WAIT held, post-WAIT lockout)
//   BTN_WAIT / BTN_START : bit positions of each button in the btn_held vector
//   cnt_width() : width needed to hold values 0..n (at least 1 bit)
package button_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HELD    = 2'd1,
    S_LOCKOUT = 2'd2
  } btn_state_e;

  localparam int BTN_WAIT  = 0;
  localparam int BTN_START = 1;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button synchronizer + debouncer.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   btn_n : raw active-low button, asynchronous to clk
//   held  : debounced level, active-high pressed
//   press : one-cycle event on the debounced released->pressed transition
// The raw pin goes through two flops before anything looks at it. The
// debounced level only follows the synchronized level after it has differed
// for DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic held,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync_0;
  logic          sync_q;
  logic          stable;    // debounced level, active-low like the pin
  logic          stable_d;  // previous debounced level, for edge detect
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_0   <= 1'b1;
      sync_q   <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
    end else begin
      sync_0   <= btn_n;
      sync_q   <= sync_0;
      stable_d <= stable;
      if (sync_q == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign held  = ~stable;
  // Only the falling (press) edge produces an event; release is silent.
  assign press = stable_d & ~stable;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner: turns raw active-low WAIT (button_0) and START
// (button_1) pins into clean one-cycle press events for the controller.
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset
//   button_0       : raw WAIT button, active-low, asynchronous
//   button_1       : raw START button, active-low, asynchronous
//   wait_pulse     : one-cycle WAIT press event (registered)
//   start_pulse    : one-cycle accepted START press event (registered)
//   btn_held       : debounced levels, [0]=WAIT, [1]=START, 1=pressed
//   suppressed_cnt : saturating count of START presses that were dropped
// A START press is dropped when it coincides with a WAIT press, arrives
// while WAIT is held, or arrives during the lockout window that follows a
// WAIT release. WAIT always wins, so the two pulses are mutually exclusive.
// The FSM state is kept in the internal signal "state" for observation.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_0,
  input  logic             button_1,
  output logic             wait_pulse,
  output logic             start_pulse,
  output logic [1:0]       btn_held,
  output logic [CNT_W-1:0] suppressed_cnt
);

  localparam int LW = cnt_width(LOCKOUT_CYCLES);

  logic [1:0]    held;
  logic [1:0]    press;
  btn_state_e    state;
  logic [LW-1:0] lock_cnt;
  logic          drop_start;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .btn_n(button_0),
    .held (held[BTN_WAIT]),
    .press(press[BTN_WAIT])
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start (
    .clk  (clk),
    .rst  (rst),
    .btn_n(button_1),
    .held (held[BTN_START]),
    .press(press[BTN_START])
  );

  assign btn_held = held;

  // A START press only survives in S_IDLE with no competing WAIT press.
  always_comb begin
    drop_start = 1'b0;
    if (press[BTN_START] && (state != S_IDLE || press[BTN_WAIT])) begin
      drop_start = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      lock_cnt       <= '0;
      wait_pulse     <= 1'b0;
      start_pulse    <= 1'b0;
      suppressed_cnt <= '0;
    end else begin
      wait_pulse  <= 1'b0;
      start_pulse <= 1'b0;

      if (drop_start && (suppressed_cnt != {CNT_W{1'b1}})) begin
        suppressed_cnt <= suppressed_cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (press[BTN_WAIT]) begin
            wait_pulse <= 1'b1;
            state      <= S_HELD;
          end else if (press[BTN_START]) begin
            start_pulse <= 1'b1;
          end
        end

        S_HELD: begin
          if (!held[BTN_WAIT]) begin
            lock_cnt <= LW'(LOCKOUT_CYCLES);
            state    <= S_LOCKOUT;
          end
        end

        S_LOCKOUT: begin
          if (press[BTN_WAIT]) begin
            wait_pulse <= 1'b1;
            lock_cnt   <= '0;
            state      <= S_HELD;
          end else if (lock_cnt == LW'(1)) begin
            // Last lockout cycle: a START press here was already dropped.
            lock_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end

        default: begin
          lock_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus a randomized run,
// all checked every cycle against a behavioural model of the pin-to-event
// rules, with literal expectations on the directed scenarios.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int D = 4;
  localparam int L = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         button_0 = 1'b1;
  logic         button_1 = 1'b1;
  logic         wait_pulse;
  logic         start_pulse;
  logic [1:0]   btn_held;
  logic [W-1:0] suppressed_cnt;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L),
    .CNT_W          (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button_0      (button_0),
    .button_1      (button_1),
    .wait_pulse    (wait_pulse),
    .start_pulse   (start_pulse),
    .btn_held      (btn_held),
    .suppressed_cnt(suppressed_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int seen_wait = 0;
  int seen_start = 0;
  int last_start_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw pin samples are delayed two edges; the debounced level follows the
  // delayed level once it has disagreed for D samples in a row. A press
  // event is seen on the edge after the debounced level falls. START is
  // rejected while WAIT is held, on a WAIT press edge, and for L edges after
  // the edge that first sees WAIT released.
  bit m_dly0[$] = '{1'b1, 1'b1};
  bit m_dly1[$] = '{1'b1, 1'b1};
  bit m_stable[2] = '{1'b1, 1'b1};
  int m_run[2] = '{0, 0};
  bit m_fell[2] = '{1'b0, 1'b0};
  bit m_held_mode = 1'b0;
  int m_lock_until = -1000000;
  bit m_wait = 1'b0;
  bit m_start = 1'b0;
  int m_cnt = 0;

  task automatic deb_step(input int b, input bit v);
    m_fell[b] = 1'b0;
    if (v == m_stable[b]) begin
      m_run[b] = 0;
    end else begin
      m_run[b]++;
      if (m_run[b] == D) begin
        if (m_stable[b]) m_fell[b] = 1'b1;
        m_stable[b] = v;
        m_run[b] = 0;
      end
    end
  endtask

  task automatic model_step();
    bit wp, sp, wl, v0, v1;
    if (rst) begin
      m_dly0 = '{1'b1, 1'b1};
      m_dly1 = '{1'b1, 1'b1};
      m_stable = '{1'b1, 1'b1};
      m_run = '{0, 0};
      m_fell = '{1'b0, 1'b0};
      m_held_mode = 1'b0;
      m_lock_until = -1000000;
      m_wait = 1'b0;
      m_start = 1'b0;
      m_cnt = 0;
    end else begin
      wp = m_fell[0];
      sp = m_fell[1];
      wl = !m_stable[0];
      m_wait = 1'b0;
      m_start = 1'b0;
      if (wp) begin
        m_wait = 1'b1;
        if (sp) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_held_mode = 1'b1;
      end else if (m_held_mode) begin
        if (sp) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (!wl) begin
          m_held_mode = 1'b0;
          m_lock_until = edge_n + L;
        end
      end else if (edge_n <= m_lock_until) begin
        if (sp) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (sp) begin
        m_start = 1'b1;
      end
      v0 = m_dly0.pop_front();
      m_dly0.push_back(button_0);
      v1 = m_dly1.pop_front();
      m_dly1.push_back(button_1);
      deb_step(0, v0);
      deb_step(1, v1);
    end
  endtask

  function automatic logic [1:0] exp_state();
    if (m_held_mode) return 2'(S_HELD);
    if (edge_n + 1 <= m_lock_until) return 2'(S_LOCKOUT);
    return 2'(S_IDLE);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    edge_n++;
    model_step();
    #1;
    chk("wait_pulse", 32'(wait_pulse), 32'(m_wait));
    chk("start_pulse", 32'(start_pulse), 32'(m_start));
    chk("btn_held", 32'(btn_held), 32'({!m_stable[1], !m_stable[0]}));
    chk("suppressed_cnt", 32'(suppressed_cnt), 32'(m_cnt));
    chk("fsm_state", 32'(dut.state), 32'(exp_state()));
    chk("pulse_exclusive", 32'(wait_pulse & start_pulse), 32'd0);
    if (wait_pulse === 1'b1) seen_wait++;
    if (start_pulse === 1'b1) begin
      seen_start++;
      last_start_edge = edge_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    button_0 = 1'b1;
    button_1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_wait = 0;
    seen_start = 0;
  endtask

  // ---------------- stimulus ----------------
  int first_low;
  int rst_edge;
  int left0, left1;

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(2);
    chk("reset_btn_held", 32'(btn_held), 32'd0);
    chk("reset_suppressed", 32'(suppressed_cnt), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(S_IDLE));

    // 1: clean START press
    seen_start = 0;
    first_low = edge_n + 1;
    button_1 = 1'b0;
    cycles(10);
    chk("t1_held_level", 32'(btn_held), 32'd2);
    button_1 = 1'b1;
    cycles(12);
    chk("t1_start_count", 32'(seen_start), 32'd1);
    chk("t1_latency", 32'(last_start_edge - first_low), 32'd6);
    chk("t1_wait_count", 32'(seen_wait), 32'd0);

    // 2: 3-cycle glitch
    seen_start = 0;
    button_1 = 1'b0;
    cycles(3);
    button_1 = 1'b1;
    cycles(12);
    chk("t2_start_count", 32'(seen_start), 32'd0);
    chk("t2_held", 32'(btn_held), 32'd0);
    chk("t2_suppressed", 32'(suppressed_cnt), 32'd0);

    // 3: WAIT then START one cycle later
    do_reset();
    button_0 = 1'b0;
    cycles(1);
    button_1 = 1'b0;
    cycles(10);
    button_0 = 1'b1;
    button_1 = 1'b1;
    cycles(30);
    chk("t3_wait_count", 32'(seen_wait), 32'd1);
    chk("t3_start_count", 32'(seen_start), 32'd0);
    chk("t3_suppressed", 32'(suppressed_cnt), 32'd1);
    chk("t3_state_idle", 32'(dut.state), 32'(S_IDLE));

    // 4: simultaneous press
    do_reset();
    button_0 = 1'b0;
    button_1 = 1'b0;
    cycles(10);
    button_0 = 1'b1;
    button_1 = 1'b1;
    cycles(30);
    chk("t4_wait_count", 32'(seen_wait), 32'd1);
    chk("t4_start_count", 32'(seen_start), 32'd0);
    chk("t4_suppressed", 32'(suppressed_cnt), 32'd1);

    // 5a: START event lands 7 cycles after debounced WAIT release
    do_reset();
    button_0 = 1'b0;
    cycles(10);
    button_0 = 1'b1;
    cycles(6);
    button_1 = 1'b0;
    cycles(10);
    button_1 = 1'b1;
    cycles(30);
    chk("t5a_start_count", 32'(seen_start), 32'd0);
    chk("t5a_suppressed", 32'(suppressed_cnt), 32'd1);

    // 5b: START event lands 12 cycles after debounced WAIT release
    do_reset();
    button_0 = 1'b0;
    cycles(10);
    button_0 = 1'b1;
    cycles(11);
    button_1 = 1'b0;
    cycles(10);
    button_1 = 1'b1;
    cycles(30);
    chk("t5b_start_count", 32'(seen_start), 32'd1);
    chk("t5b_suppressed", 32'(suppressed_cnt), 32'd0);

    // 6: reset while START held and stable
    do_reset();
    button_1 = 1'b0;
    cycles(12);
    rst = 1'b1;
    rst_edge = edge_n + 1;
    cycles(1);
    chk("t6_rst_start", 32'(start_pulse), 32'd0);
    chk("t6_rst_held", 32'(btn_held), 32'd0);
    rst = 1'b0;
    seen_start = 0;
    cycles(12);
    chk("t6_start_count", 32'(seen_start), 32'd1);
    chk("t6_latency", 32'(last_start_edge - rst_edge), 32'd7);
    button_1 = 1'b1;
    cycles(12);

    // 6b: 300 START presses while WAIT held -> saturation
    do_reset();
    button_0 = 1'b0;
    cycles(8);
    repeat (300) begin
      button_1 = 1'b0;
      cycles(5);
      button_1 = 1'b1;
      cycles(5);
    end
    chk("t6_saturated", 32'(suppressed_cnt), 32'd255);
    chk("t6_sat_start_count", 32'(seen_start), 32'd0);
    button_0 = 1'b1;
    cycles(20);

    // randomized run, model-checked every cycle
    do_reset();
    left0 = 1;
    left1 = 1;
    repeat (4000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      left0--;
      left1--;
      if (left0 <= 0) begin
        button_0 = ~button_0;
        left0 = int'($urandom_range(1, 14));
      end
      if (left1 <= 0) begin
        button_1 = ~button_1;
        left1 = int'($urandom_range(1, 14));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    button_0 = 1'b1;
    button_1 = 1'b1;
    cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
